// File: rtl/sap_1_fetch_unit.sv
// SAP-1 instruction fetch initiator: ROM address/CE driver, PC, HLT stop.
// Optional PC load (jump) support is enabled by defining SAP_1_FETCH_JUMP_EN.
module sap_1_fetch_unit #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 4,
    parameter logic [OPCODE_WIDTH-1:0] HLT_OPCODE = {OPCODE_WIDTH{1'b1}}
) (
    input  logic                           Clk,
    input  logic                           CLRbar,
    input  logic                           run,
    input  logic [DATA_WIDTH-1:0]          instruction_in,
    output logic [ADDR_WIDTH-1:0]          address_out,
    output logic                           CEbar,
    output logic [OPCODE_WIDTH-1:0]        opcode,
    output logic [DATA_WIDTH-OPCODE_WIDTH-1:0] operand,
    output logic                           instr_valid,
    input  logic                           instr_ack,
`ifdef SAP_1_FETCH_JUMP_EN
    input  logic                           pc_load,
    input  logic [ADDR_WIDTH-1:0]          pc_load_value,
`endif
    output logic [ADDR_WIDTH-1:0]          pc,
    output logic                           halted
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        READ,
        HOLD,
        HALT
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   pc_next;
    logic                    load_en;
    logic [ADDR_WIDTH-1:0]   load_value;

`ifdef SAP_1_FETCH_JUMP_EN
    assign load_en    = pc_load;
    assign load_value = pc_load_value;
`else
    assign load_en    = 1'b0;
    assign load_value = '0;
`endif

    always_ff @(posedge Clk) begin
        if (!CLRbar) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        unique case (state)
            IDLE: begin
                if (load_en) begin
                    pc_next = load_value;
                end
                if (run) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                state_next = READ;
            end
            READ: begin
                pc_next    = pc + ADDR_WIDTH'(1);
                state_next = HOLD;
            end
            HOLD: begin
                if (instr_ack) begin
                    if (opcode == HLT_OPCODE) begin
                        state_next = HALT;
                    end else begin
                        // A jump overrides the increment taken in READ.
                        if (load_en) begin
                            pc_next = load_value;
                        end
                        state_next = run ? ADDR : IDLE;
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge Clk) begin
        if (!CLRbar) begin
            pc          <= '0;
            address_out <= '0;
            CEbar       <= 1'b1;
            opcode      <= '0;
            operand     <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            pc          <= pc_next;
            CEbar       <= (state_next != READ);
            instr_valid <= (state_next == HOLD);
            halted      <= (state_next == HALT);
            if (state_next == ADDR) begin
                address_out <= pc_next;
            end
            if (state == READ) begin
                {opcode, operand} <= instruction_in;
            end
        end
    end

endmodule

// File: tb/tb_sap_1_fetch_unit.sv
// Bench for sap_1_fetch_unit: ROM model, directed phases and a random
// handshake phase checked against a fetch-order reference model.
module tb_sap_1_fetch_unit;

    logic       Clk = 1'b0;
    logic       CLRbar;
    logic       run;
    logic [7:0] instruction_in;
    logic [3:0] address_out;
    logic       CEbar;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       instr_valid;
    logic       instr_ack;
    logic       pc_load;
    logic [3:0] pc_load_value;
    logic [3:0] pc;
    logic       halted;

    logic [7:0] rom [16];
    logic [3:0] ce_q [$];
    logic [3:0] pend [$];

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    assign instruction_in = (CEbar === 1'b0) ? rom[address_out] : 8'hxx;

    // Every cycle the ROM is enabled, record the address it was given.
    always @(negedge Clk) begin
        if (CEbar === 1'b0) ce_q.push_back(address_out);
    end

    sap_1_fetch_unit dut (
        .Clk           (Clk),
        .CLRbar        (CLRbar),
        .run           (run),
        .instruction_in(instruction_in),
        .address_out   (address_out),
        .CEbar         (CEbar),
        .opcode        (opcode),
        .operand       (operand),
        .instr_valid   (instr_valid),
        .instr_ack     (instr_ack),
`ifdef SAP_1_FETCH_JUMP_EN
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
`endif
        .pc            (pc),
        .halted        (halted)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pc"}, 32'(pc), 0);
        check({tag, "_addr"}, 32'(address_out), 0);
        check({tag, "_ce"}, 32'(CEbar), 1);
        check({tag, "_op"}, 32'(opcode), 0);
        check({tag, "_opnd"}, 32'(operand), 0);
        check({tag, "_valid"}, 32'(instr_valid), 0);
        check({tag, "_halt"}, 32'(halted), 0);
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (instr_valid !== 1'b1 && edges < 20) begin
            tick();
            edges++;
        end
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 16; i++) begin
            rom[i] = 8'($urandom_range(0, 8'hEF));
        end
    endtask

    initial begin
        int e;
        int nv;
        int acc;
        logic prev_acc;
        logic [3:0] mpc;
        logic [3:0] a;
        logic [3:0] exp_addr;

        CLRbar = 1'b0;
        run = 1'b0;
        instr_ack = 1'b0;
        pc_load = 1'b0;
        pc_load_value = 4'h0;
        fill_rom();
        rom[0] = 8'h09;
        rom[1] = 8'h1A;

        // Reset and idle
        tick();
        CLRbar = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_reset("idle");
            tick();
        end

        // Single fetch with ack held high (ack before valid is ignored)
        ce_q.delete();
        run = 1'b1;
        instr_ack = 1'b1;
        wait_valid(e);
        check("b_lat", 32'(e), 3);
        check("b_op", 32'(opcode), 0);
        check("b_opnd", 32'(operand), 9);
        check("b_pc", 32'(pc), 1);
        check("b_ce_n", 32'(ce_q.size()), 1);
        if (ce_q.size() > 0) check("b_ce_addr", 32'(ce_q[0]), 0);
        run = 1'b0;
        tick();
        check("b_drop", 32'(instr_valid), 0);
        check("b_ce_idle", 32'(CEbar), 1);

        // Stall in HOLD
        instr_ack = 1'b0;
        run = 1'b1;
        wait_valid(e);
        check("c_lat", 32'(e), 3);
        ce_q.delete();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("c_valid", 32'(instr_valid), 1);
            check("c_data", 32'({opcode, operand}), 32'h1A);
        end
        check("c_no_ce", 32'(ce_q.size()), 0);
        instr_ack = 1'b1;
        e = 0;
        while (ce_q.size() == 0 && e < 10) begin
            tick();
            e++;
        end
        check("c_next_lat", 32'(e), 3);
        if (ce_q.size() > 0) check("c_next_addr", 32'(ce_q[0]), 2);
        run = 1'b0;
        wait_valid(e);
        check("c_next_data", 32'({opcode, operand}), 32'(rom[2]));
        tick();

        // Full program with wrap and halt
        CLRbar = 1'b0;
        tick();
        CLRbar = 1'b1;
        fill_rom();
        rom[15] = 8'hF0;
        ce_q.delete();
        run = 1'b1;
        instr_ack = 1'b1;
        nv = 0;
        e = 0;
        while (halted !== 1'b1 && e < 100) begin
            tick();
            e++;
            if (instr_valid === 1'b1) begin
                check("d_data", 32'({opcode, operand}), 32'(rom[nv & 15]));
                nv++;
            end
        end
        check("d_edges", 32'(e), 49);
        check("d_count", 32'(nv), 16);
        check("d_pc_wrap", 32'(pc), 0);
        check("d_ce_n", 32'(ce_q.size()), 16);
        for (int i = 0; i < ce_q.size() && i < 16; i++) begin
            check("d_ce_addr", 32'(ce_q[i]), 32'(i));
        end
        ce_q.delete();
        for (int i = 0; i < 6; i++) begin
            tick();
            check("d_halt", 32'(halted), 1);
            check("d_halt_valid", 32'(instr_valid), 0);
        end
        check("d_no_ce", 32'(ce_q.size()), 0);

        // Random run/ack against a fetch-order model
        CLRbar = 1'b0;
        tick();
        CLRbar = 1'b1;
        fill_rom();
        ce_q.delete();
        pend.delete();
        mpc = 4'h0;
        acc = 0;
        prev_acc = 1'b0;
        run = 1'b0;
        instr_ack = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (ce_q.size() > 0) begin
                a = ce_q.pop_front();
                check("r_addr", 32'(a), 32'(mpc));
                pend.push_back(a);
                mpc = mpc + 4'h1;
            end
            if (prev_acc) check("r_drop", 32'(instr_valid), 0);
            check("r_halt", 32'(halted), 0);
            if (instr_valid === 1'b1) begin
                check("r_pend", 32'(pend.size()), 1);
                if (pend.size() > 0)
                    check("r_data", 32'({opcode, operand}), 32'(rom[pend[0]]));
                check("r_pc", 32'(pc), 32'(mpc));
                check("r_ce", 32'(CEbar), 1);
            end
            run = ($urandom_range(0, 3) != 0);
            instr_ack = 1'($urandom_range(0, 1));
            prev_acc = (instr_valid === 1'b1) && instr_ack;
            if (prev_acc) begin
                if (pend.size() > 0) void'(pend.pop_front());
                acc++;
            end
        end
        check("r_progress", 32'(acc >= 20), 1);

        // Reset during READ, then refetch address 0
        rom[0] = 8'h09;
        CLRbar = 1'b0;
        run = 1'b0;
        instr_ack = 1'b1;
        tick();
        CLRbar = 1'b1;
        run = 1'b1;
        tick();
        tick();
        check("f_in_read", 32'(CEbar), 0);
        CLRbar = 1'b0;
        tick();
        check_reset("f_rst");
        CLRbar = 1'b1;
        wait_valid(e);
        check("f_lat", 32'(e), 3);
        check("f_data", 32'({opcode, operand}), 32'h09);

        // PC load on ack of address 0
        pc_load = 1'b1;
        pc_load_value = 4'hC;
        tick();
        pc_load = 1'b0;
`ifdef SAP_1_FETCH_JUMP_EN
        exp_addr = 4'hC;
`else
        exp_addr = 4'h1;
`endif
        check("g_addr", 32'(address_out), 32'(exp_addr));
        check("g_pc", 32'(pc), 32'(exp_addr));
        run = 1'b0;
        wait_valid(e);
        check("g_data", 32'({opcode, operand}), 32'(rom[exp_addr]));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
